// File: rtl/alu_mul_seq.sv
// Sequential unsigned multiplier (low WIDTH bits of a*b) that borrows the
// shared execute-stage ALU for every add and every multiplicand shift.
module alu_mul_seq #(
  parameter int         WIDTH  = 16,
  parameter logic [1:0] OP_ADD = 2'b00,
  parameter logic [1:0] OP_SHL = 2'b01
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             alu_req,
  input  logic             alu_gnt,
  output logic [WIDTH-1:0] alu_data1,
  output logic [WIDTH-1:0] alu_data2,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result
);

  // ALU handshake: alu_req is held high with stable operands until a cycle
  // with alu_gnt=1; that edge consumes alu_result. alu_gnt without alu_req
  // has no effect.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] m_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] p_reg;
  logic [WIDTH-1:0] q_next;

  assign q_next = q_reg >> 1;
  assign busy   = (state != S_IDLE);
  assign done   = (state == S_DONE);

  always_comb begin
    state_nxt = state;
    alu_req   = 1'b0;
    alu_op    = 2'b00;
    alu_data1 = '0;
    alu_data2 = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (b == '0)    state_nxt = S_DONE;
          else if (b[0])  state_nxt = S_ADD;
          else            state_nxt = S_SHIFT;
        end
      end
      S_ADD: begin
        alu_req   = 1'b1;
        alu_op    = OP_ADD;
        alu_data1 = p_reg;
        alu_data2 = m_reg;
        if (alu_gnt) state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        alu_req   = 1'b1;
        alu_op    = OP_SHL;
        alu_data1 = m_reg;
        alu_data2 = WIDTH'(1);
        if (alu_gnt) begin
          // q_reg[1] is the multiplier bit that becomes current after this shift
          if (q_next == '0)   state_nxt = S_DONE;
          else if (q_reg[1])  state_nxt = S_ADD;
          else                state_nxt = S_SHIFT;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      m_reg   <= '0;
      q_reg   <= '0;
      p_reg   <= '0;
      product <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            m_reg <= a;
            q_reg <= b;
            p_reg <= '0;
            if (b == '0) product <= '0;
          end
        end
        S_ADD: begin
          if (alu_gnt) p_reg <= alu_result;
        end
        S_SHIFT: begin
          if (alu_gnt) begin
            m_reg <= alu_result;
            q_reg <= q_next;
            // The final step is always a shift, so P is complete here and
            // product is already valid during the done cycle.
            if (q_next == '0) product <= p_reg;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle unsigned multiply controller for the 16-bit ISA.
- Computes the low WIDTH bits of a×b by sequencing the shared ALU through shift-and-add iterations. Each iteration uses ALU add (op 00) and ALU shift-left (op 01).
- Sits beside the execute stage. It requests the ALU via req/gnt and advances only on granted cycles.
- Multiplier shifting and the zero test are internal; all additions and multiplicand shifts go through the ALU.

Parameters:
- WIDTH, 16, operand/product width; must match ALU data width.
- OP_ADD, 2'b00, ALUop encoding for data1+data2 (mod 2^WIDTH).
- OP_SHL, 2'b01, ALUop encoding for logical data1 << data2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- start  in  1  request multiply; sampled only in IDLE.
- a  in  WIDTH  multiplicand, captured on accepted start.
- b  in  WIDTH  multiplier, captured on accepted start.
- busy  out  1  high in ADD, SHIFT, DONE.
- done  out  1  one-cycle pulse, product valid.
- product  out  WIDTH  low WIDTH bits of a×b; held until next accepted start.
- alu_req  out  1  ALU request, high in ADD and SHIFT.
- alu_gnt  in  1  ALU granted this cycle.
- alu_data1  out  WIDTH  ALU operand 1.
- alu_data2  out  WIDTH  ALU operand 2.
- alu_op  out  2  ALU operation.
- alu_result  in  WIDTH  ALU combinational result.

Behaviour:
- Reset (rst_n=0, async): state=IDLE; M, Q and P cleared; busy=0, done=0, product=0, alu_req=0, alu_data1=0, alu_data2=0, alu_op=0.
- Internal registers: M (multiplicand), Q (multiplier), P (accumulator), all WIDTH bits.
- IDLE, start=1 at an edge:
  - M<=a, Q<=b, P<=0.
  - Next state: b==0 → DONE; b[0]=1 → ADD; otherwise SHIFT.
  - start is ignored in every other state.
- ADD:
  - Drive alu_req=1, alu_op=OP_ADD, alu_data1=P, alu_data2=M.
  - Edge with alu_gnt=1: P<=alu_result, go to SHIFT.
  - alu_gnt=0: hold state and all registers.
- SHIFT:
  - Drive alu_req=1, alu_op=OP_SHL, alu_data1=M, alu_data2=1.
  - Edge with alu_gnt=1: M<=alu_result, Q<=Q>>1.
  - Next state: (Q>>1)==0 → DONE; Q[1]=1 → ADD; otherwise SHIFT.
  - alu_gnt=0: hold.
- DONE: done=1 and product<=P (product is visible registered from this cycle on); next state IDLE.
- Outside ADD and SHIFT: alu_req=0 and alu_data1, alu_data2, alu_op = 0. The shared ALU sees idle zeros.
- Arithmetic is modulo 2^WIDTH. Carry-out and bits shifted out of M are discarded; there is no overflow flag.
- Latency with alu_gnt tied high: start edge → done high after 1 + popcount(b) + (index of MSB set in b + 1) cycles. For b=0, done comes 1 cycle after the start edge.
- Each cycle with alu_gnt low in ADD or SHIFT adds exactly 1 cycle of latency.
- alu_gnt asserted while alu_req=0 is ignored.
- Reset asserted mid-operation aborts immediately to IDLE. product clears to 0 and no done pulse is produced.
- start held high continuously: a new operation is accepted on the first edge back in IDLE, i.e. the cycle after done.

Test Plan:
- a=3, b=5, gnt=1: states ADD,SHIFT,SHIFT,ADD,SHIFT. done 6 cycles after start edge, product=15, alu_op sequence 00,01,01,00,01.
- a=0x1234, b=0: done 1 cycle after start, product=0, alu_req never asserted.
- a=0x0100, b=0x0100, gnt=1: done at cycle 11, product=0x0000 (wrap).
- a=0xFFFF, b=0xFFFF: done at cycle 33, product=0x0001.
- a=3, b=5, gnt forced low for 3 cycles in the first ADD: alu_req stays high, P unchanged, done at cycle 9, product=15.
- a=7, b=9, rst_n pulsed low in the 3rd busy cycle: outputs immediately zero, no done. A subsequent a=2, b=3 gives product=6.
